// File: rtl/branch_trace_gen.sv
// Replays a captured taken/not-taken pattern for one static branch as (pc, ea, taken)
// beats over valid/ready, for a programmed number of passes.
module branch_trace_gen #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PAT_MAX = 16,
  localparam int unsigned LEN_W  = $clog2(PAT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target_in,
  input  logic [PAT_MAX-1:0] pat_bits,
  input  logic [LEN_W-1:0]  pat_len,
  input  logic [7:0]        repeat_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ea_out,
  output logic              out_taken,
  output logic              busy,
  output logic              done,
  output logic [15:0]       branch_count
);

  localparam int unsigned IDX_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, tgt_q, tgt_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d, eff_len;
  logic [7:0]         rep_num_q, rep_num_d, rep_q, rep_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               xfer, last_idx, last_rep, cur_taken;

  assign eff_len   = (pat_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : pat_len;
  assign xfer      = (state_q == StRun) && out_ready;
  assign last_idx  = (LEN_W'(idx_q) == len_q - LEN_W'(1));
  assign last_rep  = (rep_q == rep_num_q - 8'd1);
  assign cur_taken = pat_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Empty pattern or zero passes still produce the done handshake.
          state_d = ((eff_len == '0) || (repeat_num == 8'd0)) ? StDone : StRun;
        end
      end
      StRun:   if (xfer && last_idx && last_rep) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_num_d = rep_num_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    if ((state_q == StIdle) && start) begin
      pc_d      = pc_in;
      tgt_d     = target_in;
      pat_d     = pat_bits;
      len_d     = eff_len;
      rep_num_d = repeat_num;
      idx_d     = '0;
      rep_d     = '0;
      cnt_d     = '0;
    end else if (xfer) begin
      if (last_idx) begin
        idx_d = '0;
        rep_d = rep_q + 8'd1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      tgt_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      rep_num_q <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_num_q <= rep_num_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pc_out    = '0;
    ea_out    = '0;
    out_taken = 1'b0;
    unique case (state_q)
      StRun: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        pc_out    = pc_q;
        out_taken = cur_taken;
        ea_out    = cur_taken ? tgt_q : pc_q + ADDR_W'(4);
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign branch_count = cnt_q;

endmodule

// File: tb/tb_branch_trace_gen.sv
// Directed bench for branch_trace_gen: full runs, backpressure, PC wrap, empty runs,
// mid-run reset, ignored start and length clamping.
module tb_branch_trace_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  pc_in = '0, target_in = '0;
  logic [15:0] pat_bits = '0;
  logic [4:0]  pat_len = '0;
  logic [7:0]  repeat_num = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [4:0]  pc_out, ea_out;
  logic        out_taken, busy, done;
  logic [15:0] branch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Expected configuration for the stream model.
  logic [4:0]  cfg_pc, cfg_tgt;
  logic [15:0] cfg_pat;
  int          cfg_len;

  branch_trace_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pc_in        (pc_in),
    .target_in    (target_in),
    .pat_bits     (pat_bits),
    .pat_len      (pat_len),
    .repeat_num   (repeat_num),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pc_out       (pc_out),
    .ea_out       (ea_out),
    .out_taken    (out_taken),
    .busy         (busy),
    .done         (done),
    .branch_count (branch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [4:0] pc, input logic [4:0] tgt, input logic [15:0] pat,
                           input logic [4:0] len, input logic [7:0] rep);
    pc_in = pc; target_in = tgt; pat_bits = pat; pat_len = len; repeat_num = rep;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Checks n back-to-back beats (ready held high); pokes start and pc_in at beat `poke`.
  task automatic stream(input string tag, input int n, input int poke);
    logic tk;
    logic [4:0] ea_e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start = 1'b1;
        pc_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      tk   = cfg_pat[k % cfg_len];
      ea_e = tk ? cfg_tgt : cfg_pc + 5'd4;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_pc"}, pc_out, cfg_pc);
      check({tag, "_taken"}, out_taken, tk);
      check({tag, "_ea"}, ea_out, ea_e);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_valid_end"}, out_valid, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_count"}, branch_count, n);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    logic [4:0] ea_t1 [5] = '{5'd9, 5'd16, 5'd9, 5'd9, 5'd16};
    logic       tk_t1 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int items, vcyc;
    logic rdy;

    // Reset state
    #7;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ea", ea_out, 0);
    check("rst_count", branch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back, 4 passes of 5
    configure(5'd12, 5'd9, 16'b01101, 5'd5, 8'd4);
    cfg_pc = 5'd12; cfg_tgt = 5'd9; cfg_pat = 16'b01101; cfg_len = 5;
    pulse_start();
    stream("t1", 20, -1);

    // 2: ready toggling 0/1 from the first valid cycle
    out_ready = 1'b0;
    pulse_start();
    items = 0; vcyc = 0; rdy = 1'b0;
    for (int c = 0; c < 100 && items < 20; c++) begin
      @(negedge clk);
      check("t2_valid", out_valid, 1);
      if (out_valid) vcyc++;
      check("t2_ea", ea_out, ea_t1[items % 5]);
      check("t2_taken", out_taken, tk_t1[items % 5]);
      check("t2_pc", pc_out, 5'd12);
      out_ready = rdy;
      if (rdy && out_valid) items++;
      rdy = ~rdy;
    end
    check("t2_items", items, 20);
    check("t2_valid_cycles", vcyc, 40);
    @(negedge clk);
    out_ready = 1'b1;
    check("t2_done", done, 1);
    check("t2_count", branch_count, 20);

    // 3: not-taken with PC+4 wrap
    configure(5'd30, 5'd7, 16'b0, 5'd3, 8'd1);
    cfg_pc = 5'd30; cfg_tgt = 5'd7; cfg_pat = 16'b0; cfg_len = 3;
    pulse_start();
    stream("t3", 3, -1);

    // 4: empty runs
    configure(5'd12, 5'd9, 16'b01101, 5'd0, 8'd4);
    pulse_start();
    @(negedge clk);
    check("t4a_done", done, 1);
    check("t4a_valid", out_valid, 0);
    check("t4a_count", branch_count, 0);
    @(negedge clk);
    check("t4a_done_1cyc", done, 0);
    configure(5'd12, 5'd9, 16'b01101, 5'd5, 8'd0);
    pulse_start();
    @(negedge clk);
    check("t4b_done", done, 1);
    check("t4b_valid", out_valid, 0);
    @(negedge clk);
    check("t4b_valid_after", out_valid, 0);

    // 5: reset after 7 transfers, then a fresh run
    configure(5'd12, 5'd9, 16'b01101, 5'd5, 8'd4);
    cfg_pc = 5'd12; cfg_tgt = 5'd9; cfg_pat = 16'b01101; cfg_len = 5;
    pulse_start();
    for (int k = 0; k < 7; k++) @(negedge clk);
    @(negedge clk);
    check("t5_pre_count", branch_count, 7);
    rst_n = 1'b0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_pc", pc_out, 0);
    check("t5_ea", ea_out, 0);
    check("t5_taken", out_taken, 0);
    check("t5_count", branch_count, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_done_rel", done, 0);
    pulse_start();
    stream("t5r", 20, -1);

    // 6: start and pc_in change mid-run are ignored; length clamps to 16
    configure(5'd5, 5'd20, 16'hA5C3, 5'd31, 8'd1);
    cfg_pc = 5'd5; cfg_tgt = 5'd20; cfg_pat = 16'hA5C3; cfg_len = 16;
    pulse_start();
    stream("t6", 16, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
